// File: rtl/serializer_stream_if.sv
// Word-side handshake and serial-side outputs of serializer_stream.
// master = upstream/test driver, slave = the serializer itself.
interface serializer_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             msb_first;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output din, din_valid, msb_first,
        input  din_ready, dout, dout_valid, frame_start, busy
    );

    modport slave (
        input  din, din_valid, msb_first,
        output din_ready, dout, dout_valid, frame_start, busy
    );
endinterface

// File: rtl/serializer_stream.sv
// Parallel-to-serial converter: one-entry holding buffer feeding a shifter
// that emits one bit per clock, selectable bit order per word, optional
// trailing even-parity bit. Frames stream back to back with no idle gap.
module serializer_stream #(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 0
) (
    input  logic              clock_in,
    input  logic              reset_n,
    serializer_stream_if.slave bus
);
    localparam int FRAME = WIDTH + PARITY_EN;
    localparam int CW    = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] hold_data, shift_data;
    logic             hold_msb, hold_full, shift_msb;
    logic [CW-1:0]    cnt, cnt_inc;
    logic             dout_q, dout_valid_q, frame_start_q;
    logic             load, accept, din_ready, at_last;
    logic             first_bit, next_bit;

    // din_ready depends only on registered state, never on din_valid
    assign din_ready = ~hold_full | load;
    assign accept    = bus.din_valid & din_ready;

    // FSM state register
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next state, load decision and the bit to present on the next edge
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        next_bit  = 1'b0;
        at_last   = (cnt == LAST);
        cnt_inc   = cnt + CW'(1);
        first_bit = hold_msb ? hold_data[WIDTH-1] : hold_data[0];

        if (state == IDLE) begin
            if (hold_full) begin
                load      = 1'b1;
                state_nxt = SHIFT;
            end
        end else begin
            if (at_last) begin
                if (hold_full) load = 1'b1;
                else           state_nxt = IDLE;
            end
        end

        // bit index i maps to data bit i (LSB-first) or WIDTH-1-i (MSB-first)
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_inc == CW'(i))
                next_bit = shift_msb ? shift_data[WIDTH-1-i] : shift_data[i];
        end
        // parity covers the whole word regardless of bit order
        if (PARITY_EN != 0 && cnt_inc == LAST)
            next_bit = ^shift_data;
    end

    // holding buffer: accept wins over the clear caused by a same-edge load
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hold_data <= '0;
            hold_msb  <= 1'b0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= bus.din;
            hold_msb  <= bus.msb_first;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // shifter word and bit counter; cnt stops at LAST until load or idle
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            shift_data <= '0;
            shift_msb  <= 1'b0;
            cnt        <= '0;
        end else if (load) begin
            shift_data <= hold_data;
            shift_msb  <= hold_msb;
            cnt        <= '0;
        end else if (state == SHIFT && !at_last) begin
            cnt <= cnt_inc;
        end
    end

    // registered serial outputs
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            dout_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (load) begin
            dout_q        <= first_bit;
            dout_valid_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else if (state == SHIFT && !at_last) begin
            dout_q        <= next_bit;
            dout_valid_q  <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            dout_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign bus.din_ready   = din_ready;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = (state == SHIFT) | hold_full;

endmodule

// File: doc/serializer_stream.md
# serializer_stream

Parametrised parallel-to-serial converter for the 8-bit SerDes system and its wider variants. It accepts words over a valid/ready handshake into a one-entry holding buffer, then shifts each word out one bit per clock_in cycle. Bit order is selectable per word, and an optional even-parity bit can be appended. Back-to-back words stream with no idle gap, and frame_start marks the first bit of each frame for the downstream deserializer.

## Interface
Parameters:
- WIDTH, 8, data word width in bits; legal range ≥ 2.
- PARITY_EN, 0, 1 appends one even-parity bit after the data bits.
- Derived: FRAME = WIDTH + PARITY_EN bits per frame. The bit counter is $clog2(FRAME) bits wide.

Ports:
- clock_in  in  1  serial bit clock; all logic on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- din  in  WIDTH  parallel word.
- din_valid  in  1  din (and msb_first) are presented.
- din_ready  out  1  block can accept a word this cycle.
- msb_first  in  1  bit order of the offered word: 1 = bit WIDTH-1 first, 0 = bit 0 first. Sampled only on acceptance.
- dout  out  1  serial data, registered.
- dout_valid  out  1  dout carries a frame bit.
- frame_start  out  1  high for exactly the cycle dout carries bit 0 of a frame.
- busy  out  1  shifter active or holding buffer full.

## Operation
- Storage:
  - Holding buffer: hold_data, hold_msb, hold_full.
  - Shifter: shift_data, shift_msb, bit counter cnt.
  - FSM: IDLE and SHIFT.
- Acceptance: occurs on an edge where din_valid && din_ready. It captures din and msb_first into the holding buffer and sets hold_full.
- load: asserted when hold_full && (state==IDLE || (state==SHIFT && cnt==FRAME-1)).
- din_ready = ~hold_full | load. This is combinational from registered state only, with no path from din_valid. It allows accept and load on the same edge; the holding buffer then takes the new word.
- On load:
  - The shifter takes the holding buffer contents.
  - cnt <= 0, state <= SHIFT.
  - dout is the first bit; dout_valid=1, frame_start=1.
  - hold_full clears unless a simultaneous accept refills it.
- In SHIFT with cnt<FRAME-1 and no load: cnt <= cnt+1, and dout presents the next bit. frame_start=0.
- Bit index i (0..WIDTH-1) is data bit i when LSB-first, and bit WIDTH-1-i when MSB-first.
- If PARITY_EN, bit index WIDTH is the XOR-reduction of the full data word. Parity is independent of bit order.
- In SHIFT with cnt==FRAME-1 and no load: state <= IDLE, dout <= 0, dout_valid <= 0.
- In IDLE without load: dout=0, dout_valid=0, frame_start=0.
- busy = (state==SHIFT) | hold_full.
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE, cnt=0, hold_full=0, all data registers 0.
  - Outputs: dout=0, dout_valid=0, frame_start=0, busy=0, din_ready=1.
  - A partial frame is dropped. No partial bits are emitted after reset is released.

## Timing
- Latency: word accepted at edge E0 with the shifter idle → first bit on dout after E1. The last bit is on dout after E(FRAME).
- Throughput: one frame per FRAME cycles. With the holding buffer refilled before the last bit, dout_valid stays continuously high across frames. frame_start pulses every FRAME cycles.
- Backpressure:
  - With the shifter active and hold_full=1, din_ready=0 until the load edge.
  - The upstream must hold din and din_valid stable until acceptance.
  - din_valid with din_ready=0 has no effect.
- Mode change between words takes effect at the frame boundary only. A msb_first change mid-frame never alters the frame in flight.
- cnt never exceeds FRAME-1. There is no wrap-around other than load or return to IDLE.

## Test plan
- WIDTH=8, PARITY_EN=0, din=0xA5, msb_first=0, single accept at E0 → dout after E1..E8 = 1,0,1,0,0,1,0,1. frame_start high after E1 only. dout_valid low after E9.
- Same word with msb_first=1 → dout = 1,0,1,0,0,1,0,1 (0xA5 is a bit-palindrome). Then send 0x01 MSB-first → 0,0,0,0,0,0,0,1; LSB-first → 1,0,0,0,0,0,0,0.
- Back-to-back 0x11, 0x22, 0x33 with din_valid held high → 24 consecutive dout_valid=1 cycles. frame_start after E1, E9, E17. din_ready low from E1 until each load edge.
- PARITY_EN=1, din=0x07 LSB-first → 9-bit frame 1,1,1,0,0,0,0,0,1. din=0x03 → parity bit 0. Frame period is 9 cycles.
- Backpressure: two words offered while a frame is in flight → the second is accepted immediately into the holding buffer. A third sees din_ready=0 until the load edge at cnt==FRAME-1, then is accepted on that same edge.
- Assert reset_n low after bit 3 of a frame, with hold_full=1 → all outputs immediately 0 and din_ready=1. After release, no bits are emitted until a new accept.
